// File: rtl/result_drain_pkg.sv
// Shared types and defaults for the detection result drain.
package pkg_resultDrain;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_X_BITS = 10;
  localparam int unsigned DEF_Y_BITS = 10;
  localparam int unsigned DEF_S_BITS = 5;
  localparam int unsigned DEF_CNT_W  = 16;

  // Wide enough for any supported queue width; the module slices it down.
  localparam logic [63:0] END_MARKER = '1;

  typedef enum logic [2:0] {
    S_Reset   = 3'd0,
    S_Ready   = 3'd1,
    S_Pop     = 3'd2,
    S_Capture = 3'd3,
    S_Present = 3'd4,
    S_Done    = 3'd5
  } STATES_t;

endpackage

// File: rtl/result_drain.sv
// Drains packed detections from the result queue, filters by frame width,
// and presents them on a valid/ready host stream with per-frame totals.
module result_drain
  import pkg_resultDrain::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned X_BITS = DEF_X_BITS,
  parameter int unsigned Y_BITS = DEF_Y_BITS,
  parameter int unsigned S_BITS = DEF_S_BITS,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_BITS-1:0] frame_w,
  output logic              ready,
  input  logic              rq_empty,
  output logic              rq_rd,
  input  logic [DATA_W-1:0] rq_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_BITS-1:0] out_x,
  output logic [Y_BITS-1:0] out_y,
  output logic [S_BITS-1:0] out_scale,
  output logic              done,
  output logic [CNT_W-1:0]  det_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned       FIELD_W  = X_BITS + Y_BITS + S_BITS;
  localparam logic [DATA_W-1:0] END_WORD = END_MARKER[DATA_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  STATES_t           state_q, state_d;
  logic [X_BITS-1:0] frame_w_q, frame_w_d;
  logic [X_BITS-1:0] out_x_q, out_x_d;
  logic [Y_BITS-1:0] out_y_q, out_y_d;
  logic [S_BITS-1:0] out_scale_q, out_scale_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  det_count_q, det_count_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic [X_BITS-1:0] cap_x;
  logic [Y_BITS-1:0] cap_y;
  logic [S_BITS-1:0] cap_scale;

  assign cap_x     = rq_data[FIELD_W-1 -: X_BITS];
  assign cap_y     = rq_data[Y_BITS+S_BITS-1 -: Y_BITS];
  assign cap_scale = rq_data[S_BITS-1:0];

  always_comb begin
    state_d      = state_q;
    frame_w_d    = frame_w_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_scale_d  = out_scale_q;
    out_valid_d  = out_valid_q;
    det_count_d  = det_count_q;
    drop_count_d = drop_count_q;
    rq_rd        = 1'b0;

    case (state_q)
      S_Reset: state_d = S_Ready;
      S_Ready: begin
        if (start) begin
          frame_w_d    = frame_w;
          det_count_d  = '0;
          drop_count_d = '0;
          state_d      = S_Pop;
        end
      end
      S_Pop: begin
        if (!rq_empty) begin
          rq_rd   = 1'b1;
          state_d = S_Capture;
        end
      end
      S_Capture: begin
        if (rq_data == END_WORD) begin
          state_d = S_Done;
        end else if (cap_x >= frame_w_q) begin
          if (drop_count_q != CNT_MAX) drop_count_d = drop_count_q + 1'b1;
          state_d = S_Pop;
        end else begin
          out_x_d     = cap_x;
          out_y_d     = cap_y;
          out_scale_d = cap_scale;
          out_valid_d = 1'b1;
          state_d     = S_Present;
        end
      end
      S_Present: begin
        if (out_ready) begin
          if (det_count_q != CNT_MAX) det_count_d = det_count_q + 1'b1;
          out_valid_d = 1'b0;
          state_d     = S_Pop;
        end
      end
      S_Done:  state_d = S_Ready;
      default: state_d = S_Reset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_Reset;
      frame_w_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_scale_q  <= '0;
      out_valid_q  <= 1'b0;
      det_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_w_q    <= frame_w_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_scale_q  <= out_scale_d;
      out_valid_q  <= out_valid_d;
      det_count_q  <= det_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign ready      = (state_q == S_Ready);
  assign done       = (state_q == S_Done);
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_scale  = out_scale_q;
  assign det_count  = det_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_result_drain.sv
// Randomized and directed bench for result_drain; a wide-counter and a
// 2-bit-counter instance share one modelled result queue.
module tb_result_drain;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, rq_empty, out_ready;
  logic [9:0]  frame_w;
  logic [31:0] rq_data;

  logic        ready, rq_rd, out_valid, done;
  logic [9:0]  out_x, out_y;
  logic [4:0]  out_scale;
  logic [15:0] det_count, drop_count;

  logic        b_ready, b_rq_rd, b_out_valid, b_done;
  logic [9:0]  b_out_x, b_out_y;
  logic [4:0]  b_out_scale;
  logic [1:0]  b_det_count, b_drop_count;

  result_drain #(.DATA_W(32), .X_BITS(10), .Y_BITS(10), .S_BITS(5), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_w(frame_w), .ready(ready),
    .rq_empty(rq_empty), .rq_rd(rq_rd), .rq_data(rq_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_scale(out_scale),
    .done(done), .det_count(det_count), .drop_count(drop_count)
  );

  result_drain #(.DATA_W(32), .X_BITS(10), .Y_BITS(10), .S_BITS(5), .CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .start(start), .frame_w(frame_w), .ready(b_ready),
    .rq_empty(rq_empty), .rq_rd(b_rq_rd), .rq_data(rq_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_x(b_out_x), .out_y(b_out_y), .out_scale(b_out_scale),
    .done(b_done), .det_count(b_det_count), .drop_count(b_drop_count)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] rq_q[$];
  logic [31:0] fr[$];
  logic [24:0] exp_out[$];
  logic [24:0] got[$];
  int exp_det, exp_drop, exp_det_b, exp_drop_b;
  int done_cnt = 0;
  int or_mode = 1;
  int stall_pct = 0;
  bit force_empty = 1'b0;
  bit have_prev = 1'b0;
  logic rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= rq_rd;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] key(input int x, input int y, input int s);
    logic [9:0] xb, yb;
    logic [4:0] sb;
    xb = 10'(x); yb = 10'(y); sb = 5'(s);
    return {xb, yb, sb};
  endfunction

  function automatic logic [31:0] mkw(input int x, input int y, input int s);
    return {7'd0, key(x, y, s)};
  endfunction

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Reference: a frame forwards, in order, every word before the end marker
  // whose x is below the frame width; the rest are counted as drops.
  task automatic model_frame(input int fw);
    int nk, nd;
    logic [31:0] w;
    nk = 0; nd = 0;
    for (int i = 0; i < fr.size(); i++) begin
      w = fr[i];
      if (w == END_W) break;
      if (int'(w[24:15]) >= fw) nd++;
      else begin
        exp_out.push_back(w[24:0]);
        nk++;
      end
    end
    exp_det = sat(nk, 16); exp_drop = sat(nd, 16);
    exp_det_b = sat(nk, 2); exp_drop_b = sat(nd, 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rd_seen && rq_q.size() > 0) rq_data = rq_q.pop_front();
    rq_empty = force_empty || ($urandom_range(0, 99) < stall_pct) || (rq_q.size() == 0);
    case (or_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rq_q.delete();
    exp_out.delete();
    force_empty = 1'b0;
    have_prev = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic begin_frame(input int fw);
    int budget;
    budget = 200;
    while (!ready && budget > 0) begin tick(); budget--; end
    if (!ready) begin
      check("wait_ready_timeout", 0, 1);
      do_reset();
    end
    if (have_prev) begin
      check("hold_det_count", det_count, exp_det);
      check("hold_drop_count", drop_count, exp_drop);
    end
    model_frame(fw);
    foreach (fr[i]) rq_q.push_back(fr[i]);
    rq_empty = force_empty || (rq_q.size() == 0);
    got.delete();
    start = 1'b1;
    frame_w = 10'(fw);
    tick();
    frame_w = 10'($urandom);
  endtask

  task automatic wait_done();
    int start_cnt, budget;
    start_cnt = done_cnt;
    budget = 3000;
    while (done_cnt == start_cnt && budget > 0) begin
      tick();
      if (done_cnt != start_cnt) break;
      start = !ready && ($urandom_range(0, 7) == 0);
      budget--;
    end
    start = 1'b0;
    if (done_cnt == start_cnt) begin
      check("done_timeout", 0, 1);
      do_reset();
    end else have_prev = 1'b1;
  endtask

  // Output checker: protocol, stability, ordering and end-of-frame totals.
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [24:0] prev_f = '0;
  always @(negedge clk) begin
    logic [24:0] act, expv;
    if (!resetn) begin
      prev_v = 1'b0;
    end else begin
      if ((rq_rd || b_rq_rd) && rq_empty) check("rq_rd_when_empty", 1, 0);
      act = {out_x, out_y, out_scale};
      if (prev_v && !prev_r) begin
        check("valid_held", out_valid, 1);
        check("fields_stable", act, prev_f);
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check("unexpected_entry", act, 0);
        else begin
          expv = exp_out.pop_front();
          check("entry", act, expv);
          check("sat_inst_valid", b_out_valid, 1);
          check("sat_inst_entry", {b_out_x, b_out_y, b_out_scale}, expv);
        end
        got.push_back(act);
      end
      if (done) begin
        done_cnt++;
        check("done_det_count", det_count, exp_det);
        check("done_drop_count", drop_count, exp_drop);
        check("done_missing_entries", exp_out.size(), 0);
        check("sat_inst_done", b_done, 1);
        check("sat_det_count", b_det_count, exp_det_b);
        check("sat_drop_count", b_drop_count, exp_drop_b);
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_f = act;
    end
  end

  initial begin
    int cnt, budget, n, fw, x;
    logic [31:0] up, w;
    resetn = 1'b0; start = 1'b0; frame_w = '0; rq_empty = 1'b1;
    out_ready = 1'b0; rq_data = '0;
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_rq_rd", rq_rd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_fields", {out_x, out_y, out_scale}, 0);
    check("rst_det", det_count, 0);
    check("rst_drop", drop_count, 0);
    resetn = 1'b1;
    check("ready_at_release", ready, 0);
    tick();
    check("ready_after_release", ready, 1);

    // Two in-range entries forwarded in order.
    fr = '{mkw(5, 7, 2), mkw(100, 40, 0), END_W};
    begin_frame(320); wait_done();
    check("f1_count", got.size(), 2);
    if (got.size() == 2) begin
      check("f1_e0", got[0], 25'(10'd5 * 2**15 + 10'd7 * 2**5 + 2));
      check("f1_e1", got[1], 25'(100 * 2**15 + 40 * 2**5 + 0));
    end
    check("f1_det", det_count, 2);
    check("f1_drop", drop_count, 0);

    // x at/above frame width is dropped.
    fr = '{mkw(330, 1, 1), mkw(319, 2, 3), END_W};
    begin_frame(320); wait_done();
    check("f2_count", got.size(), 1);
    if (got.size() == 1) check("f2_e0", got[0], 25'(319 * 2**15 + 2 * 2**5 + 3));
    check("f2_det", det_count, 1);
    check("f2_drop", drop_count, 1);

    // Host backpressure for ten cycles.
    or_mode = 2;
    fr = '{mkw(10, 20, 4), END_W};
    begin_frame(320);
    budget = 50;
    while (!out_valid && budget > 0) begin tick(); budget--; end
    cnt = 0;
    repeat (10) begin cnt += int'(out_valid); tick(); end
    check("bp_valid_cycles", cnt, 10);
    or_mode = 1; out_ready = 1'b1;
    wait_done();
    check("bp_det", det_count, 1);

    // Empty queue stall after start.
    force_empty = 1'b1;
    fr = '{mkw(1, 2, 3), END_W};
    begin_frame(320);
    cnt = 0;
    repeat (20) begin cnt += int'(rq_rd) + int'(out_valid); tick(); end
    check("empty_no_activity", cnt, 0);
    force_empty = 1'b0;
    wait_done();
    check("empty_det", det_count, 1);

    // Saturation of the 2-bit instance.
    fr = '{mkw(1, 1, 1), mkw(2, 2, 2), mkw(3, 3, 3), mkw(4, 4, 4), mkw(5, 5, 5), END_W};
    begin_frame(1023); wait_done();
    check("sat5_wide_det", det_count, 5);
    check("sat5_narrow_det", b_det_count, 3);

    // Reset while an entry is being presented.
    or_mode = 2;
    fr = '{mkw(3, 3, 3), mkw(4, 4, 4), END_W};
    begin_frame(320);
    budget = 50;
    while (!out_valid && budget > 0) begin tick(); budget--; end
    check("pre_reset_valid", out_valid, 1);
    resetn = 1'b0;
    rq_q.delete(); exp_out.delete(); have_prev = 1'b0;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_det", det_count, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_ready", ready, 0);
    resetn = 1'b1;
    check("midrst_ready_release", ready, 0);
    tick();
    check("midrst_ready_after", ready, 1);

    // Randomized frames with random backpressure and queue stalls.
    or_mode = 0;
    for (int f = 0; f < 40; f++) begin
      stall_pct = $urandom_range(0, 50);
      case ($urandom_range(0, 5))
        0:       fw = 0;
        1:       fw = 1023;
        default: fw = $urandom_range(1, 1023);
      endcase
      n = $urandom_range(0, 8);
      fr.delete();
      for (int i = 0; i < n; i++) begin
        do begin
          up = $urandom;
          if ($urandom_range(0, 1) == 1) x = fw + $urandom_range(0, 4) - 2;
          else x = $urandom_range(0, 1023);
          if (x < 0) x = 0;
          if (x > 1023) x = 1023;
          w = {up[31:25], key(x, $urandom_range(0, 1023), $urandom_range(0, 31))};
          if ($urandom_range(0, 15) == 0) w = 32'hFFFF_FFFE;
        end while (w == END_W);
        fr.push_back(w);
      end
      fr.push_back(END_W);
      begin_frame(fw);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
